// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the iterative magnitude comparator:
//   - state_t : FSM state encoding (IDLE / RUN / DONE)
//   - res_t   : one-hot result vector {gt, eq, lt} and its constants GT/EQ/LT
//   - resolve : maps the "a chunk already differed" flag and its direction
//               onto the one-hot result vector
// -----------------------------------------------------------------------------
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result vector layout is {gt, eq, lt}; exactly one bit is set once a
  // compare has completed, all-zero only out of reset.
  typedef logic [2:0] res_t;

  localparam res_t GT   = 3'b100;
  localparam res_t EQ   = 3'b010;
  localparam res_t LT   = 3'b001;
  localparam res_t NONE = 3'b000;

  // If no chunk ever differed the operands are equal; otherwise the first
  // differing chunk alone decides the direction.
  function automatic res_t resolve(input logic decided, input logic is_gt);
    if (!decided) begin
      return EQ;
    end
    return is_gt ? GT : LT;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// -----------------------------------------------------------------------------
// cmp_chunk
// Combinational unsigned compare of one C-bit chunk. Signed operands are
// mapped to offset binary before they reach this block, so an unsigned
// compare is always correct here.
// Ports:
//   a, b : C-bit chunk operands
//   gt   : a > b
//   eq   : a == b
// -----------------------------------------------------------------------------
module cmp_chunk #(
  parameter int C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  output logic         gt,
  output logic         eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/seq_magnitude_cmp.sv
// -----------------------------------------------------------------------------
// seq_magnitude_cmp
// Iterative W-bit magnitude comparator. Operands are latched on accept and
// compared C bits per cycle, most significant chunk first. The first chunk
// that differs fixes the result; later chunks cannot change it.
//
// Parameters:
//   W      : operand width (integer multiple of C)
//   C      : chunk width compared per cycle, N = W/C chunks
//   SIGNED : 0 = unsigned, 1 = two's-complement compare
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   start  : compare request, accepted only while ready is high
//   a, b   : operands, sampled on accept only
//   ready  : high while idle
//   done   : one-cycle pulse when gt/eq/lt have been updated
//   gt/eq/lt : registered result, held until the next completed compare
//
// Build option:
//   CMP_EARLY_EXIT_EN : when defined, the compare finishes in the cycle the
//   first differing chunk is seen. Otherwise every compare takes N chunk
//   cycles (data-independent latency). Results are identical either way.
// -----------------------------------------------------------------------------
module seq_magnitude_cmp
  import cmp_pkg::*;
#(
  parameter int W      = 16,
  parameter int C      = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int N     = W / C;
  localparam int CNT_W = $clog2(N + 1);

  // Flipping the sign bit of both operands turns a two's-complement order
  // into an unsigned order, so the chunk datapath never needs to know.
  localparam logic [W-1:0] SIGN_FLIP = SIGNED ? {1'b1, {(W-1){1'b0}}} : '0;

  state_t           state_q;
  logic [W-1:0]     a_sh_q;
  logic [W-1:0]     b_sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic             decided_q;
  logic             gt_prov_q;
  logic             ready_q;
  logic             done_q;
  res_t             res_q;

  logic             chunk_gt;
  logic             chunk_eq;
  logic             decided_d;
  logic             gt_prov_d;
  logic             run_fin;

  cmp_chunk #(
    .C (C)
  ) u_chunk (
    .a  (a_sh_q[W-1 -: C]),
    .b  (b_sh_q[W-1 -: C]),
    .gt (chunk_gt),
    .eq (chunk_eq)
  );

  // Provisional result after folding in the current top chunk, and whether
  // this RUN cycle is the last one.
  always_comb begin
    decided_d = decided_q;
    gt_prov_d = gt_prov_q;
    if (!decided_q && !chunk_eq) begin
      decided_d = 1'b1;
      gt_prov_d = chunk_gt;
    end
    run_fin = (cnt_q == CNT_W'(1));
`ifdef CMP_EARLY_EXIT_EN
    // Any differing chunk is necessarily the first one in this build,
    // because the compare never continues past it.
    if (!chunk_eq) begin
      run_fin = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_prov_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      res_q     <= NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q    <= a ^ SIGN_FLIP;
            b_sh_q    <= b ^ SIGN_FLIP;
            cnt_q     <= CNT_W'(N);
            decided_q <= 1'b0;
            gt_prov_q <= 1'b0;
            ready_q   <= 1'b0;
            state_q   <= RUN;
          end
        end

        RUN: begin
          a_sh_q    <= a_sh_q << C;
          b_sh_q    <= b_sh_q << C;
          cnt_q     <= cnt_q - CNT_W'(1);
          decided_q <= decided_d;
          gt_prov_q <= gt_prov_d;
          if (run_fin) begin
            // Result and done are registered together so they become
            // visible in the same cycle.
            res_q   <= resolve(decided_d, gt_prov_d);
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready         = ready_q;
  assign done          = done_q;
  assign {gt, eq, lt}  = res_q;

endmodule

// File: doc/seq_magnitude_cmp.md
# seq_magnitude_cmp

Parametrised, iterative magnitude comparator. Compares two W-bit operands C bits per cycle, MSB chunk first, and reports gt/eq/lt through a start/done handshake. Unsigned or two's-complement mode is selected at elaboration. It is the multi-cycle successor to the team's fixed-width combinational greater-than circuits and serves datapaths where a wide single-cycle compare would limit clock rate.

## Interface
- W, 16, operand width in bits; must be an integer multiple of C.
- C, 4, chunk width compared per cycle; N = W/C chunks.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a compare; accepted only when ready=1.
- a  input  W  operand A, sampled on accept.
- b  input  W  operand B, sampled on accept.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when a result is valid.
- gt  output  1  a > b.
- eq  output  1  a == b.
- lt  output  1  a < b.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1, latch a and b into shift registers and load the chunk counter with N. If SIGNED=1, invert the MSB of both latched operands (offset-binary mapping). Go to RUN.
- RUN: compare the top C bits of both shift registers, then shift left by C and decrement the counter.
  - The first unequal chunk fixes the provisional result (gt or lt). Later chunks never overwrite it.
  - If all chunks are equal, the result is eq.
  - Leave RUN after the last chunk, or early per Configuration.
- DONE: register gt/eq/lt (exactly one high), pulse done, then return to IDLE.
- gt/eq/lt hold their value until the next DONE. They are valid whenever ready=1 after the first compare.
- start is ignored outside IDLE. Operands are not re-sampled mid-compare.
- Reset (at any time, including mid-RUN): state=IDLE, ready=1, done=0, gt=eq=lt=0, internal registers cleared. Any compare in progress is abandoned with no done pulse.

## Timing
- Accept edge = cycle 0.
- RUN chunk k (1..N) is evaluated in cycle k.
- done is high in the cycle after the deciding chunk: cycle N+1 worst case.
- ready drops the cycle after accept and returns the cycle after done. The next accept is possible at cycle (done cycle + 1), so start held high gives back-to-back compares.
- Outputs are registered. There is no combinational path from a/b/start to any output.

## Configuration
- CMP_EARLY_EXIT_EN defined:
  - RUN exits to DONE in the cycle a chunk differs. done arrives at cycle k+1 for first-differing chunk k.
  - Equal operands still take N chunks.
- Undefined:
  - Always N chunk cycles. done is always at cycle N+1, giving data-independent latency.
  - Results are identical in both builds.

## Structure
- Package cmp_pkg holds:
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Result encoding constants: GT, EQ, LT.
- Sub-module cmp_chunk: combinational C-bit compare with outputs gt and eq. Instantiated once on the top chunk of the shift registers.
- Top level holds the FSM, shift registers, chunk counter and result registers. Target is 150–250 lines.

## Test plan
All cases use W=16, C=4.
- SIGNED=0, a=0x1234, b=0x1233 → gt=1, eq=lt=0. done at cycle 5 in both builds (difference is in chunk 4).
- SIGNED=0, a=0x8000, b=0x7FFF → gt=1. done at cycle 2 with CMP_EARLY_EXIT_EN, cycle 5 without. With SIGNED=1, same stimulus → lt=1.
- a=b=0xBEEF → eq=1, done at cycle 5. Then a=0x0000, b=0xFFFF with start held high → accepted at cycle 6, lt=1.
- Start a compare, pulse start again during RUN with different operands → ignored; the result reflects the first operands only, and exactly one done pulse occurs.
- Assert reset in cycle 2 of RUN → next cycle ready=1, done=0, gt=eq=lt=0, no done pulse. A following compare (a=3, b=5) → lt=1.
- Randomised sweep of 1000 pairs per mode against a reference model → result matches, exactly one of gt/eq/lt is high, and done latency matches the Timing rules for the build.
